// File: rtl/fib_bcd.sv
// fib_bcd: iterative binary-to-BCD converter (double-dabble, one bit per clock).
// Captures INP on a rising edge of IE, shifts BITS times, then presents the
// packed digits on BCD with a one-cycle OE pulse. OVF flags values that did
// not fit in DIGITS digits; BCD then holds the value modulo 10^DIGITS.
module fib_bcd #(
    parameter int BITS   = 32,
    parameter int DIGITS = 10
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [BITS-1:0]       INP,
    input  logic                  IE,
    output logic                  BUSY,
    output logic [4*DIGITS-1:0]   BCD,
    output logic                  OE,
    output logic                  OVF
);

    localparam int AW = 4 * DIGITS;
    localparam int CW = $clog2(BITS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            ie_q, ie_d;
    logic [BITS-1:0] bin_q, bin_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [AW-1:0]   acc_adj;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovf_acc_q, ovf_acc_d;
    logic [AW-1:0]   bcd_q, bcd_d;
    logic            ovf_q, ovf_d;
    logic            oe_q, oe_d;

    // Add-3 correction: every digit >= 5 is bumped so the following shift carries correctly.
    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Next-state and datapath: load on start, shift per clock, publish in DONE.
    always_comb begin
        state_d   = state_q;
        ie_d      = IE;
        bin_d     = bin_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_acc_d = ovf_acc_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        oe_d      = 1'b0;
        case (state_q)
            IDLE: begin
                // Only a rising edge starts; edges while busy are dropped, not queued.
                if (IE && !ie_q) begin
                    bin_d     = INP;
                    acc_d     = '0;
                    cnt_d     = CW'(BITS);
                    ovf_acc_d = 1'b0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                // The bit leaving the top digit is exactly the part that does not fit.
                acc_d     = {acc_adj[AW-2:0], bin_q[BITS-1]};
                bin_d     = {bin_q[BITS-2:0], 1'b0};
                ovf_acc_d = ovf_acc_q | acc_adj[AW-1];
                cnt_d     = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_d   = acc_q;
                ovf_d   = ovf_acc_q;
                oe_d    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            ie_q      <= 1'b0;
            bin_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_acc_q <= 1'b0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            oe_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            ie_q      <= ie_d;
            bin_q     <= bin_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_acc_q <= ovf_acc_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
            oe_q      <= oe_d;
        end
    end

    assign BUSY = (state_q != IDLE);
    assign BCD  = bcd_q;
    assign OVF  = ovf_q;
    assign OE   = oe_q;

endmodule

// File: tb/tb_fib_bcd.sv
// tb_fib_bcd: scoreboard bench for fib_bcd. Two instances: default 32-bit/10-digit
// and a narrow 8-bit/2-digit one for the overflow cases. Stimulus pushes expected
// results; per-instance monitors pop and compare on every OE.
module tb_fib_bcd;

    localparam int BA = 32;
    localparam int DA = 10;
    localparam int BB = 8;
    localparam int DB = 2;

    typedef struct {
        logic [39:0] bcd;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic            clk;
    logic            rst;
    logic [BA-1:0]   inp_a;
    logic            ie_a;
    logic            busy_a;
    logic [4*DA-1:0] bcd_a;
    logic            oe_a;
    logic            ovf_a;
    logic [BB-1:0]   inp_b;
    logic            ie_b;
    logic            busy_b;
    logic [4*DB-1:0] bcd_b;
    logic            oe_b;
    logic            ovf_b;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea;
    exp_t eb;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   run_a    = 0;
    int   run_b    = 0;

    fib_bcd #(.BITS(BA), .DIGITS(DA)) u_dut_a (
        .CLK(clk), .RST(rst), .INP(inp_a), .IE(ie_a),
        .BUSY(busy_a), .BCD(bcd_a), .OE(oe_a), .OVF(ovf_a)
    );

    fib_bcd #(.BITS(BB), .DIGITS(DB)) u_dut_b (
        .CLK(clk), .RST(rst), .INP(inp_b), .IE(ie_b),
        .BUSY(busy_b), .BCD(bcd_b), .OE(oe_b), .OVF(ovf_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor A: compare digits, overflow, latency and busy length on each OE.
    always @(negedge clk) begin
        if (oe_a) begin
            if (qa.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL a_unexpected_oe actual=%0h required=no_output", bcd_a);
            end else begin
                ea = qa.pop_front();
                chk("a_bcd", bcd_a, ea.bcd);
                chk("a_ovf", ovf_a, ea.ovf);
                chk("a_latency", cyc, ea.cyc);
                chk("a_busy_len", run_a, BA + 1);
            end
        end
        if (busy_a) run_a++; else run_a = 0;
    end

    // Monitor B: same checks for the narrow instance.
    always @(negedge clk) begin
        if (oe_b) begin
            if (qb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL b_unexpected_oe actual=%0h required=no_output", bcd_b);
            end else begin
                eb = qb.pop_front();
                chk("b_bcd", {32'b0, bcd_b}, eb.bcd);
                chk("b_ovf", ovf_b, eb.ovf);
                chk("b_latency", cyc, eb.cyc);
                chk("b_busy_len", run_b, BB + 1);
            end
        end
        if (busy_b) run_b++; else run_b = 0;
    end

    // Drive a start on A at the next negedge and record what must come back.
    task automatic start_a(input logic [BA-1:0] v, input logic [39:0] e, input logic ov);
        @(negedge clk);
        inp_a = v;
        ie_a  = 1'b1;
        qa.push_back('{bcd: e, ovf: ov, cyc: cyc + BA + 2});
    endtask

    task automatic start_b(input logic [BB-1:0] v, input logic [7:0] e, input logic ov);
        @(negedge clk);
        inp_b = v;
        ie_b  = 1'b1;
        qb.push_back('{bcd: {32'b0, e}, ovf: ov, cyc: cyc + BB + 2});
    endtask

    task automatic wait_a(input string name);
        int n;
        n = 0;
        while (qa.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (qa.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout actual=%0d_pending required=0", name, qa.size());
            qa.delete();
        end
    endtask

    task automatic wait_b(input string name);
        int n;
        n = 0;
        while (qb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (qb.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout actual=%0d_pending required=0", name, qb.size());
            qb.delete();
        end
    endtask

    logic [31:0] vec_in  [6];
    logic [39:0] vec_exp [6];
    logic [7:0]  nb_in   [4];
    logic [7:0]  nb_exp  [4];
    logic        nb_ovf  [4];

    initial begin
        vec_in[0] = 32'd1;          vec_exp[0] = 40'h0000000001;
        vec_in[1] = 32'hFFFFFFFF;   vec_exp[1] = 40'h4294967295;
        vec_in[2] = 32'd999999999;  vec_exp[2] = 40'h0999999999;
        vec_in[3] = 32'd1000000000; vec_exp[3] = 40'h1000000000;
        vec_in[4] = 32'd65535;      vec_exp[4] = 40'h0000065535;
        vec_in[5] = 32'h80000000;   vec_exp[5] = 40'h2147483648;
        nb_in[0] = 8'd255; nb_exp[0] = 8'h55; nb_ovf[0] = 1'b1;
        nb_in[1] = 8'd99;  nb_exp[1] = 8'h99; nb_ovf[1] = 1'b0;
        nb_in[2] = 8'd100; nb_exp[2] = 8'h00; nb_ovf[2] = 1'b1;
        nb_in[3] = 8'd42;  nb_exp[3] = 8'h42; nb_ovf[3] = 1'b0;

        rst   = 1'b1;
        ie_a  = 1'b0;
        ie_b  = 1'b0;
        inp_a = '0;
        inp_b = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy_a, 0);
        chk("rst_oe", oe_a, 0);
        chk("rst_ovf", ovf_a, 0);
        chk("rst_bcd", bcd_a, 0);
        chk("rst_b_busy", busy_b, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Zero input, single-cycle IE pulse.
        start_a(32'd0, 40'h0, 1'b0);
        @(negedge clk);
        ie_a = 1'b0;
        chk("a_busy_after_start", busy_a, 1);
        wait_a("zero");

        // Directed table.
        for (int i = 0; i < 6; i++) begin
            start_a(vec_in[i], vec_exp[i], 1'b0);
            @(negedge clk);
            ie_a = 1'b0;
            wait_a("table");
        end

        // Fibonacci term 144 with IE held high well past a second conversion window.
        start_a(32'd144, 40'h0000000144, 1'b0);
        repeat (80) @(negedge clk);
        wait_a("fib_hold");
        ie_a = 1'b0;
        @(negedge clk);

        // Start while busy: new edge with INP=7 ten cycles in must be ignored.
        start_a(32'd144, 40'h0000000144, 1'b0);
        @(negedge clk);
        ie_a = 1'b0;
        repeat (8) @(negedge clk);
        @(negedge clk);
        inp_a = 32'd7;
        ie_a  = 1'b1;
        wait_a("busy_start");
        repeat (40) @(negedge clk);
        ie_a = 1'b0;
        @(negedge clk);

        // Reset mid-conversion with IE held high: abort, then restart on the next edge.
        @(negedge clk);
        inp_a = 32'd12345678;
        ie_a  = 1'b1;
        repeat (16) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", busy_a, 0);
        chk("mid_rst_bcd", bcd_a, 0);
        chk("mid_rst_oe", oe_a, 0);
        rst = 1'b0;
        qa.push_back('{bcd: 40'h0012345678, ovf: 1'b0, cyc: cyc + BA + 2});
        wait_a("rst_restart");
        ie_a = 1'b0;

        // Narrow instance: overflow and truncation.
        for (int i = 0; i < 4; i++) begin
            start_b(nb_in[i], nb_exp[i], nb_ovf[i]);
            @(negedge clk);
            ie_b = 1'b0;
            wait_b("narrow");
        end

        // Quiet period to catch any stray output.
        repeat (60) @(negedge clk);
        chk("a_queue_empty", qa.size(), 0);
        chk("b_queue_empty", qb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fib_bcd.md
# fib_bcd

Binary-to-BCD converter placed directly downstream of the Fibonacci module. It captures the binary term when the Fibonacci module signals completion, converts it to packed decimal digits with the iterative shift-add-3 (double-dabble) method, and presents the digits to the display/print stage with a one-cycle valid pulse. One bit is converted per clock. Overflow is flagged when `DIGITS` is too small for the value.

## Interface
- `BITS`, 32: width of the binary input; must match the Fibonacci module's `BITS`.
- `DIGITS`, 10: number of BCD digits produced. 10 covers a 32-bit input.

- `CLK`  in  1: clock; all state updates on the rising edge.
- `RST`  in  1: reset, synchronous, active-high.
- `INP`  in  `BITS`: binary value; connects to Fibonacci `OUT`.
- `IE`  in  1: input valid; connects to Fibonacci `OE`; may be held high for many cycles.
- `BUSY`  out  1: high while a conversion is in progress (state ≠ IDLE).
- `BCD`  out  `4*DIGITS`: packed result. Digit 0 (units) is in `BCD[3:0]`; the most significant digit is at the top.
- `OE`  out  1: one-cycle pulse; `BCD`/`OVF` are valid from this cycle.
- `OVF`  out  1: the value did not fit in `DIGITS` digits; valid with `OE`.

## Operation
- Internal registers:
  - `ie_q`: previous `IE`.
  - `bin`: shift register, `BITS` wide.
  - `acc`: working BCD register, `4*DIGITS` wide.
  - `cnt`: shift counter, `$clog2(BITS+1)` wide.
  - `ovf_acc`: sticky overflow flag.
  - `state` ∈ {IDLE, SHIFT, DONE}.
- **Start condition:** `IE` rising, i.e. `IE=1 && ie_q=0`. A level-high `IE` yields exactly one conversion.
- **IDLE:** on start, load `bin←INP`, `acc←0`, `cnt←BITS`, `ovf_acc←0`, then go to SHIFT. Otherwise stay in IDLE.
- **SHIFT:** one iteration per clock.
  1. Every 4-bit digit of `acc` that is ≥5 gets +3.
  2. `{acc,bin}` shifts left by 1.
  3. The bit shifted out of the top of `acc` is ORed into `ovf_acc`.
  4. `cnt` decrements.
  - When the iteration executed is the one with `cnt==1`, go to DONE.
- **DONE:** `BCD←acc`, `OVF←ovf_acc`, `OE←1`, go to IDLE.
- **Output hold:** `BCD` and `OVF` hold their values until the next DONE. `OE` is 0 in every cycle other than the one following DONE.
- **Truncation:** when `OVF=1`, `BCD` holds `INP mod 10^DIGITS`.
- **Start while busy:** an `IE` rising edge while `BUSY=1` is ignored. It is not queued, and `INP` is not sampled. The upstream module must hold its result until `BUSY=0`.
- `ie_q` updates every cycle, regardless of state.
- **Reset** sets: `state=IDLE`, `BUSY=0`, `OE=0`, `OVF=0`, `BCD=0`, `ie_q=0`, `bin=0`, `acc=0`, `cnt=0`, `ovf_acc=0`.
  - Reset mid-conversion aborts it. No `OE` is produced and `BCD` returns to 0.
  - Reset takes priority over a start on the same edge.
  - If `IE` is still high on the first edge after reset, it counts as a rising edge (`ie_q=0`) and starts a conversion.

## Timing
- **Edge E0:** start sampled. `BUSY=1` from E0.
- **Edges E1..E`BITS`:** shift iterations. The state is DONE after E`BITS`.
- **Edge E`BITS+1`:** `OE=1` and `BCD` valid. `BUSY=0` from this same edge.
- **Latency:** `BITS+1` cycles from the start edge to the `OE` edge (33 at default).
- **Back-to-back:** the next start can be sampled at the `OE` edge + 1 at the earliest, which requires `IE` to go low and then high again. Minimum throughput is one conversion per `BITS+2` cycles.
- Because `BUSY` is combinational from `state`, it changes on the same edges as `state`.

## Test plan
- **Zero input:** reset, then `INP=0` with an `IE` rising edge → `OE` pulses exactly 33 cycles after the start edge, `BCD=0`, `OVF=0`, `BUSY` high for 33 cycles.
- **Fibonacci term:** chain after the Fibonacci module with index 12 (term 144) → `BCD=40'h0000000144`, `OVF=0`; exactly one `OE` even though Fibonacci `OE` stays high.
- **Maximum value:** `INP=32'hFFFFFFFF` → `BCD=40'h4294967295`, `OVF=0`.
- **Overflow:** `BITS=8`, `DIGITS=2`, `INP=255` → `BCD=8'h55`, `OVF=1`, latency 9 cycles. A subsequent `INP=99` gives `BCD=8'h99`, `OVF=0`.
- **Start while busy:** issue an `IE` rising edge with `INP=7` at cycle 10 of a conversion of 144 → result is still `BCD=...144`, a single `OE`, and no second conversion.
- **Reset mid-conversion:** assert `RST` for one cycle at shift cycle 15 while `IE` stays high → no `OE` for the aborted conversion. A new conversion of the current `INP` starts on the edge after reset and completes 33 cycles later with the correct digits.
